// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared widths, FSM encodings and helpers for the SPI slave receiver
package spi_pkg;

    localparam int SPI_BYTE_W = 8;
    localparam int SPI_CNT_W  = 3;

    localparam logic [SPI_CNT_W-1:0] SPI_CNT_LAST = SPI_CNT_W'(SPI_BYTE_W - 1);

    // One-hot receiver states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b01,
        ST_SHIFT = 2'b10
    } spi_state_e;

    // True when the synchronised CS level means "selected"
    function automatic logic cs_is_active(input logic cs_level, input logic active_high);
        return cs_level == active_high;
    endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// rtl/spi_rx_fifo.sv - synchronous FIFO holding {first, data} words for the SPI receiver
module spi_rx_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign pop_data = mem_q[rd_ptr_q];

    // A pop frees the slot in the same cycle, so a full FIFO still takes a simultaneous push
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only observed once written
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - SPI slave byte receiver with valid/ready output; SPI_RX_FIFO_EN selects FIFO storage
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter bit CS_ACTIVE_HIGH = 1'b1,
    parameter bit SAMPLE_RISE    = 1'b0,
    parameter int SYNC_STAGES    = 2,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  spi_cs,
    input  logic                  spi_sck,
    input  logic                  spi_sdi,
    output logic [SPI_BYTE_W-1:0] rx_data,
    output logic                  rx_first,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_overrun,
    output logic                  frame_err,
    input  logic                  ovr_clr,
    output logic                  busy
);

    localparam logic CS_IDLE = CS_ACTIVE_HIGH ? 1'b0 : 1'b1;

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("spi_slave_rx: SYNC_STAGES must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("spi_slave_rx: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
    logic                   sck_prev_q, sck_prev_d;

    spi_state_e             state_q, state_d;
    logic [SPI_CNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic [SPI_BYTE_W-2:0]  shift_q, shift_d;
    logic                   first_q, first_d;
    logic                   push_q, push_d;
    logic [SPI_BYTE_W:0]    push_word_q, push_word_d;
    logic                   frame_err_q, frame_err_d;
    logic                   busy_q, busy_d;
    logic                   ovr_q, ovr_d;

    logic cs_s, sck_s, sdi_s, cs_act, sample_edge;
    logic store_ok;

    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign sck_s       = sck_sync_q[SYNC_STAGES-1];
    assign sdi_s       = sdi_sync_q[SYNC_STAGES-1];
    assign cs_act      = cs_is_active(cs_s, CS_ACTIVE_HIGH);
    // sdi travels through the same depth as sck so it is sampled alongside the edge it belongs to
    assign sample_edge = SAMPLE_RISE ? (sck_s && !sck_prev_q) : (!sck_s && sck_prev_q);

    // Synchroniser shift, edge-detect history, FSM next state, shifter and status
    always_comb begin
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
        sdi_sync_d  = {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi};
        sck_prev_d  = sck_s;

        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        first_d     = first_q;
        push_d      = 1'b0;
        push_word_d = push_word_q;
        frame_err_d = 1'b0;
        busy_d      = cs_act;

        unique case (state_q)
            ST_IDLE: begin
                bitcnt_d = '0;
                shift_d  = '0;
                first_d  = 1'b1;
                if (cs_act) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!cs_act) begin
                    // An edge coinciding with CS release is dropped along with any partial byte
                    state_d     = ST_IDLE;
                    frame_err_d = (bitcnt_q != '0);
                    bitcnt_d    = '0;
                    shift_d     = '0;
                    first_d     = 1'b1;
                end else if (sample_edge) begin
                    shift_d = {shift_q[SPI_BYTE_W-3:0], sdi_s};
                    if (bitcnt_q == SPI_CNT_LAST) begin
                        push_d      = 1'b1;
                        push_word_d = {first_q, shift_q, sdi_s};
                        first_d     = 1'b0;
                        bitcnt_d    = '0;
                    end else begin
                        bitcnt_d = bitcnt_q + SPI_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A fresh overrun outranks a simultaneous clear
        ovr_d = ovr_q;
        if (ovr_clr) begin
            ovr_d = 1'b0;
        end
        if (push_q && !store_ok) begin
            ovr_d = 1'b1;
        end
    end

    // Receiver state registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cs_sync_q   <= {SYNC_STAGES{CS_IDLE}};
            sck_sync_q  <= '0;
            sdi_sync_q  <= '0;
            sck_prev_q  <= 1'b0;
            state_q     <= ST_IDLE;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            first_q     <= 1'b1;
            push_q      <= 1'b0;
            push_word_q <= '0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            cs_sync_q   <= cs_sync_d;
            sck_sync_q  <= sck_sync_d;
            sdi_sync_q  <= sdi_sync_d;
            sck_prev_q  <= sck_prev_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            first_q     <= first_d;
            push_q      <= push_d;
            push_word_q <= push_word_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
            ovr_q       <= ovr_d;
        end
    end

    assign rx_overrun = ovr_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

`ifdef SPI_RX_FIFO_EN
    logic                fifo_pop, fifo_full, fifo_empty;
    logic [SPI_BYTE_W:0] fifo_dout;

    assign fifo_pop = !fifo_empty && rx_ready;
    assign store_ok = !fifo_full || fifo_pop;

    spi_rx_fifo #(
        .WIDTH (SPI_BYTE_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (push_q && store_ok),
        .push_data (push_word_q),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rx_valid = !fifo_empty;
    assign rx_first = fifo_empty ? 1'b0 : fifo_dout[SPI_BYTE_W];
    assign rx_data  = fifo_empty ? '0 : fifo_dout[SPI_BYTE_W-1:0];
`else
    logic                hold_valid_q, hold_valid_d;
    logic [SPI_BYTE_W:0] hold_word_q, hold_word_d;
    logic                hold_pop;

    assign hold_pop = hold_valid_q && rx_ready;
    assign store_ok = !hold_valid_q || hold_pop;

    // Single holding register: emptied by a pop, refilled by an accepted push in the same cycle
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_word_d  = hold_word_q;
        if (hold_pop) begin
            hold_valid_d = 1'b0;
        end
        if (push_q && store_ok) begin
            hold_valid_d = 1'b1;
            hold_word_d  = push_word_q;
        end
    end

    // Holding register state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_valid_q <= 1'b0;
            hold_word_q  <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_word_q  <= hold_word_d;
        end
    end

    assign rx_valid = hold_valid_q;
    assign rx_first = hold_word_q[SPI_BYTE_W];
    assign rx_data  = hold_word_q[SPI_BYTE_W-1:0];
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb/tb_spi_slave_rx.sv - scoreboard bench for spi_slave_rx with a bit-banged SPI master model
`timescale 1ns/1ps
module tb_spi_slave_rx;

    localparam int SYNC = 2;
`ifdef SPI_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       spi_cs = 1'b0, spi_sck = 1'b0, spi_sdi = 1'b0;
    logic       rx_ready = 1'b0, ovr_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_first, rx_valid, rx_overrun, frame_err, busy;

    logic       cs2 = 1'b1, sck2 = 1'b0, sdi2 = 1'b0;
    logic       ready2 = 1'b1, ovr_clr2 = 1'b0;
    logic [7:0] rx_data2;
    logic       rx_first2, rx_valid2, rx_overrun2, frame_err2, busy2;

    int         n_vec = 0, n_bad = 0;
    logic [8:0] exp_q[$];
    logic [8:0] exp2_q[$];
    int         fe_pulses = 0, fe_cycles = 0;
    logic       fe_prev = 1'b0;
    time        last_edge_t = 0, valid_rise_t = 0;
    int         cyc = 0;
    bit         rand_mode = 1'b0;
    logic       ready_set = 1'b1;

    spi_slave_rx dut (
        .clk_i(clk), .rst_i(rst_i), .spi_cs(spi_cs), .spi_sck(spi_sck), .spi_sdi(spi_sdi),
        .rx_data(rx_data), .rx_first(rx_first), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_overrun(rx_overrun), .frame_err(frame_err), .ovr_clr(ovr_clr), .busy(busy)
    );

    spi_slave_rx #(.CS_ACTIVE_HIGH(1'b0), .SAMPLE_RISE(1'b1)) dut2 (
        .clk_i(clk), .rst_i(rst_i), .spi_cs(cs2), .spi_sck(sck2), .spi_sdi(sdi2),
        .rx_data(rx_data2), .rx_first(rx_first2), .rx_valid(rx_valid2), .rx_ready(ready2),
        .rx_overrun(rx_overrun2), .frame_err(frame_err2), .ovr_clr(ovr_clr2), .busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Consumer ready: either a fixed level or random with a guaranteed accept every 4th cycle
    always @(posedge clk) begin
        #1;
        cyc++;
        rx_ready = rand_mode ? (($urandom_range(0, 3) != 0) || (cyc % 4 == 0)) : ready_set;
    end

    // Scoreboard monitors: pop an expected word whenever a handshake is about to complete
    always @(negedge clk) begin
        if (!rst_i && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_byte: got 0x%0h first=%0d with nothing expected", rx_data, rx_first);
            end else begin
                logic [8:0] w;
                w = exp_q.pop_front();
                check("rx_data", rx_data, w[7:0]);
                check("rx_first", rx_first, w[8]);
            end
        end
        if (!rst_i && rx_valid2 && ready2) begin
            if (exp2_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_byte2: got 0x%0h with nothing expected", rx_data2);
            end else begin
                logic [8:0] w2;
                w2 = exp2_q.pop_front();
                check("rx_data2", rx_data2, w2[7:0]);
                check("rx_first2", rx_first2, w2[8]);
            end
        end
        if (frame_err) fe_cycles++;
        if (frame_err && !fe_prev) fe_pulses++;
        fe_prev = frame_err;
    end

    always @(posedge rx_valid) valid_rise_t = $time;

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master: data changes with SCK rise, slave samples on the following fall (mid-bit)
    task automatic drive_bits(input logic [7:0] b, input int nbits, input int h);
        for (int i = 0; i < nbits; i++) begin
            spi_sdi = b[7-i];
            spi_sck = 1'b1;
            wait_clk(h);
            spi_sck = 1'b0;
            last_edge_t = $time;
            wait_clk(h);
        end
    endtask

    task automatic send_frame(input logic [7:0] bytes[$], input int h, input bit exp_en);
        spi_cs = 1'b1;
        wait_clk(h);
        foreach (bytes[i]) begin
            if (exp_en) exp_q.push_back({(i == 0) ? 1'b1 : 1'b0, bytes[i]});
            drive_bits(bytes[i], 8, h);
        end
        spi_cs = 1'b0;
        wait_clk(2 * h);
    endtask

    // Active-low CS, data changes with SCK fall, slave samples on the rise
    task automatic send_rise(input logic [7:0] b, input int h);
        exp2_q.push_back({1'b1, b});
        cs2 = 1'b0;
        wait_clk(h);
        for (int i = 0; i < 8; i++) begin
            sdi2 = b[7-i];
            wait_clk(h);
            sck2 = 1'b1;
            wait_clk(h);
            sck2 = 1'b0;
        end
        wait_clk(h);
        cs2 = 1'b1;
        wait_clk(2 * h);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || exp2_q.size() != 0) && t < 2000) begin
            wait_clk(1);
            t++;
        end
        check(name, exp_q.size() + exp2_q.size(), 0);
        wait_clk(10);
    endtask

    initial begin
        logic [7:0] fr[$];
        int fe0, fc0, n, h;

        wait_clk(3);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_data", rx_data, 0);
        check("reset_rx_first", rx_first, 0);
        check("reset_overrun", rx_overrun, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_busy", busy, 0);
        rst_i = 1'b0;
        wait_clk(5);

        // Four single-byte frames at 1 MHz SCK
        for (int b = 1; b <= 4; b++) begin
            fr = '{8'(b)};
            send_frame(fr, 50, 1'b1);
        end
        drain("drain_single_frames");
        check("t1_frame_err", fe_pulses, 0);
        check("t1_overrun", rx_overrun, 0);

        // Latency from 8th sampling edge to rx_valid, with the byte held by ready=0
        ready_set = 1'b0;
        wait_clk(2);
        fr = '{8'h6C};
        send_frame(fr, 8, 1'b1);
        check("latency_ns", 32'(valid_rise_t - last_edge_t), (SYNC + 2) * 10 - 5);
        check("held_valid", rx_valid, 1);
        check("held_data", rx_data, 8'h6C);
        ready_set = 1'b1;
        drain("drain_latency");

        // Multi-byte frame: only the first byte carries rx_first
        fr = '{8'hA5, 8'h3C, 8'hFF};
        send_frame(fr, 20, 1'b1);
        drain("drain_multi");
        check("t2_frame_err", fe_pulses, 0);

        // Overrun when storage is full, then cleared by ovr_clr
        ready_set = 1'b0;
        wait_clk(2);
        for (int k = 0; k < 6; k++) begin
            fr = '{8'(8'h10 + k)};
            send_frame(fr, 8, k < CAP);
            check("overrun_after_byte", rx_overrun, k >= CAP);
        end
        ovr_clr = 1'b1;
        wait_clk(1);
        ovr_clr = 1'b0;
        wait_clk(1);
        check("overrun_cleared", rx_overrun, 0);
        ready_set = 1'b1;
        drain("drain_overrun");

        // Partial byte: CS drops after 5 bits
        fe0 = fe_pulses;
        fc0 = fe_cycles;
        spi_cs = 1'b1;
        wait_clk(8);
        drive_bits(8'hC3, 5, 8);
        spi_cs = 1'b0;
        wait_clk(16);
        check("frame_err_pulses", fe_pulses - fe0, 1);
        check("frame_err_width", fe_cycles - fc0, 1);
        check("partial_not_pushed", rx_valid, 0);
        fr = '{8'h81};
        send_frame(fr, 8, 1'b1);
        drain("drain_after_partial");

        // Reset mid-byte with a held byte pending
        ready_set = 1'b0;
        wait_clk(2);
        fr = '{8'h11};
        send_frame(fr, 8, 1'b0);
        spi_cs = 1'b1;
        wait_clk(8);
        drive_bits(8'hF0, 4, 8);
        rst_i = 1'b1;
        wait_clk(1);
        check("midrst_valid", rx_valid, 0);
        check("midrst_data", rx_data, 0);
        check("midrst_first", rx_first, 0);
        check("midrst_busy", busy, 0);
        check("midrst_frame_err", frame_err, 0);
        check("midrst_overrun", rx_overrun, 0);
        rst_i = 1'b0;
        spi_cs = 1'b0;
        fe0 = fe_pulses;
        wait_clk(20);
        ready_set = 1'b1;
        fr = '{8'h5A};
        send_frame(fr, 8, 1'b1);
        drain("drain_after_reset");
        check("post_reset_frame_err", fe_pulses - fe0, 0);

        // Rising-edge sampling, active-low CS, minimum SCK half-period
        send_rise(8'h96, SYNC + 2);
        send_rise(8'($urandom_range(0, 255)), SYNC + 2);
        drain("drain_rise");

        // Random frames with a random consumer
        rand_mode = 1'b1;
        fe0 = fe_pulses;
        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(1, 4);
            fr = {};
            for (int i = 0; i < n; i++) fr.push_back(8'($urandom_range(0, 255)));
            h = $urandom_range(SYNC + 2, 10);
            send_frame(fr, h, 1'b1);
        end
        drain("drain_random");
        rand_mode = 1'b0;
        check("random_overrun", rx_overrun, 0);
        check("random_frame_err", fe_pulses - fe0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
